csi2_packet_ctrl: RTL and testbench

CSI2_PACKET_CTRL -- requirements
Module: csi2_packet_ctrl

---
 rtl/csi2_pkg.sv | 18 +
 rtl/csi2_ecc.sv | 20 ++
 rtl/csi2_packet_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_csi2_packet_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/csi2_pkg.sv
// Shared CSI-2 definitions: data-type codes and the packet controller state set.
package csi2_pkg;

    localparam logic [5:0] DT_FS       = 6'h00;
    localparam logic [5:0] DT_FE       = 6'h01;
    localparam logic [5:0] DT_LS       = 6'h02;
    localparam logic [5:0] DT_LE       = 6'h03;
    localparam logic [5:0] DT_LONG_MIN = 6'h10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HDR      = 3'd1,
        PAYLOAD  = 3'd2,
        CRC      = 3'd3,
        WAIT_EOT = 3'd4
    } state_t;

endpackage

// File: rtl/csi2_ecc.sv
// CSI-2 packet-header ECC: 6 parity bits over the 24-bit header {WC[15:8], WC[7:0], DI}.
module csi2_ecc (
    input  logic [23:0] i_data,
    output logic [5:0]  o_ecc
);

    // Each parity bit is the XOR of the header bits selected by its mask.
    localparam logic [23:0] ECC_MASK [6] = '{
        24'hF12CB7, 24'hF2555B, 24'h749A6D,
        24'hB8E38E, 24'hDF03F0, 24'hEFFC00
    };

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_parity
            assign o_ecc[gi] = ^(i_data & ECC_MASK[gi]);
        end
    endgenerate

endmodule

// File: rtl/csi2_packet_ctrl.sv
// Two-lane CSI-2 packet controller: pairs lane bytes into beats, decodes the
// header, tracks frame/line status and streams payload beats.
// Optional header ECC check is enabled by defining CSI2_ECC_CHECK_EN.
module csi2_packet_ctrl
    import csi2_pkg::*;
#(
    parameter int SKEW_MAX = 7
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        l0_hs_mode,
    input  logic        l1_hs_mode,
    input  logic        l0_found_sot,
    input  logic        l1_found_sot,
    input  logic        l0_byte_gate,
    input  logic        l1_byte_gate,
    input  logic [7:0]  l0_byte,
    input  logic [7:0]  l1_byte,
    output logic [15:0] pix_data,
    output logic [1:0]  pix_be,
    output logic        pix_valid,
    output logic [1:0]  pkt_vc,
    output logic [5:0]  pkt_dt,
    output logic [15:0] pkt_wc,
    output logic        hdr_valid,
    output logic        frame_valid,
    output logic        line_valid,
    output logic        ecc_err,
    output logic        skew_err,
    output logic        trunc_err
);

    localparam int SW = $clog2(SKEW_MAX + 1) + 1;

    state_t         r_state, w_state_next;
    logic           r_l0_full, r_l1_full;
    logic [7:0]     r_l0_byte, r_l1_byte;
    logic [SW-1:0]  r_skew_cnt;
    logic           r_hdr_cnt;
    logic [7:0]     r_hdr_di, r_hdr_wc_lo;
    logic [15:0]    r_remain;

    logic           w_cap, w_trunc, w_beat, w_one_full, w_skew;
    logic           w_hdr_done, w_hdr_ok, w_ecc_bad, w_short, w_pay_beat;
    logic [15:0]    w_wc;
    logic [5:0]     w_dt;

    // Lanes are only listened to while a packet is in flight.
    assign w_cap      = (r_state == HDR) || (r_state == PAYLOAD) || (r_state == CRC);
    assign w_trunc    = w_cap && !(l0_hs_mode && l1_hs_mode);
    assign w_beat     = w_cap && r_l0_full && r_l1_full && !w_trunc;
    assign w_one_full = w_cap && (r_l0_full ^ r_l1_full);
    assign w_skew     = w_one_full && !w_trunc && (r_skew_cnt == SW'(SKEW_MAX));

    // Second header beat: lane 0 holds WC[15:8], lane 1 holds the ECC byte.
    assign w_hdr_done = (r_state == HDR) && w_beat && r_hdr_cnt;
    assign w_wc       = {r_l0_byte, r_hdr_wc_lo};
    assign w_dt       = r_hdr_di[5:0];
    assign w_short    = (w_dt < DT_LONG_MIN);
    assign w_hdr_ok   = w_hdr_done && !w_ecc_bad;
    assign w_pay_beat = (r_state == PAYLOAD) && w_beat;

`ifdef CSI2_ECC_CHECK_EN
    logic [5:0] w_ecc;
    logic       r_ecc_err;

    csi2_ecc u_ecc (
        .i_data ({r_l0_byte, r_hdr_wc_lo, r_hdr_di}),
        .o_ecc  (w_ecc)
    );

    assign w_ecc_bad = (w_ecc != r_l1_byte[5:0]);

    // ECC failure pulses alongside hdr_valid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_ecc_err <= 1'b0;
        else       r_ecc_err <= w_hdr_done && w_ecc_bad;
    end
    assign ecc_err = r_ecc_err;
`else
    assign w_ecc_bad = 1'b0;
    assign ecc_err   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state decode; truncation wins over skew, skew over beat handling.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (l0_hs_mode && l1_hs_mode && l0_found_sot && l1_found_sot)
                    w_state_next = HDR;
            end
            HDR, PAYLOAD, CRC: begin
                if (w_trunc)
                    w_state_next = IDLE;
                else if (w_skew)
                    w_state_next = WAIT_EOT;
                else if (r_state == HDR) begin
                    if (w_hdr_done) begin
                        if (w_ecc_bad || w_short) w_state_next = WAIT_EOT;
                        else if (w_wc == 16'd0)   w_state_next = CRC;
                        else                      w_state_next = PAYLOAD;
                    end
                end else if (r_state == PAYLOAD) begin
                    // The beat carrying the last one or two payload bytes ends PAYLOAD.
                    if (w_beat && (r_remain <= 16'd2)) w_state_next = CRC;
                end else begin
                    // One beat always covers what is left of the CRC.
                    if (w_beat) w_state_next = WAIT_EOT;
                end
            end
            WAIT_EOT: begin
                if (!l0_hs_mode && !l1_hs_mode) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Lane holding registers and skew counter; emptied outside packets and on errors.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_l0_full  <= 1'b0;
            r_l1_full  <= 1'b0;
            r_l0_byte  <= 8'd0;
            r_l1_byte  <= 8'd0;
            r_skew_cnt <= '0;
        end else begin
            r_l0_full  <= w_cap && !w_skew && !w_trunc && ((r_l0_full && !w_beat) || l0_byte_gate);
            r_l1_full  <= w_cap && !w_skew && !w_trunc && ((r_l1_full && !w_beat) || l1_byte_gate);
            if (l0_byte_gate) r_l0_byte <= l0_byte;
            if (l1_byte_gate) r_l1_byte <= l1_byte;
            r_skew_cnt <= (w_one_full && !w_skew) ? r_skew_cnt + SW'(1) : '0;
        end
    end

    // Header capture, packet fields, frame/line status and remaining-byte counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hdr_cnt   <= 1'b0;
            r_hdr_di    <= 8'd0;
            r_hdr_wc_lo <= 8'd0;
            r_remain    <= 16'd0;
            pkt_vc      <= 2'd0;
            pkt_dt      <= 6'd0;
            pkt_wc      <= 16'd0;
            hdr_valid   <= 1'b0;
            frame_valid <= 1'b0;
            line_valid  <= 1'b0;
        end else begin
            r_hdr_cnt <= (r_state == HDR) ? (r_hdr_cnt ^ w_beat) : 1'b0;
            if ((r_state == HDR) && w_beat && !r_hdr_cnt) begin
                r_hdr_di    <= r_l0_byte;
                r_hdr_wc_lo <= r_l1_byte;
            end
            hdr_valid <= w_hdr_done;
            if (w_hdr_ok) begin
                pkt_vc <= r_hdr_di[7:6];
                pkt_dt <= w_dt;
                pkt_wc <= w_wc;
                if (w_short) begin
                    case (w_dt)
                        DT_FS: frame_valid <= 1'b1;
                        DT_FE: begin
                            frame_valid <= 1'b0;
                            line_valid  <= 1'b0;
                        end
                        DT_LS: line_valid <= 1'b1;
                        DT_LE: line_valid <= 1'b0;
                        default: ;
                    endcase
                end else begin
                    r_remain <= w_wc;
                end
            end else if (w_pay_beat) begin
                r_remain <= (r_remain >= 16'd2) ? r_remain - 16'd2 : 16'd0;
            end
        end
    end

    // Payload beat output and error pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pix_data  <= 16'd0;
            pix_be    <= 2'b00;
            pix_valid <= 1'b0;
            skew_err  <= 1'b0;
            trunc_err <= 1'b0;
        end else begin
            pix_valid <= w_pay_beat;
            if (w_pay_beat) begin
                pix_data <= {r_l1_byte, r_l0_byte};
                // A single remaining byte means the odd lane carries CRC byte 0.
                pix_be   <= (r_remain == 16'd1) ? 2'b01 : 2'b11;
            end
            skew_err  <= w_skew;
            trunc_err <= w_trunc;
        end
    end

endmodule

// File: tb/tb_csi2_packet_ctrl.sv
// Directed testbench for csi2_packet_ctrl (both with and without CSI2_ECC_CHECK_EN).
module tb_csi2_packet_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        l0_hs_mode, l1_hs_mode, l0_found_sot, l1_found_sot;
    logic        l0_byte_gate, l1_byte_gate;
    logic [7:0]  l0_byte, l1_byte;
    logic [15:0] pix_data;
    logic [1:0]  pix_be;
    logic        pix_valid;
    logic [1:0]  pkt_vc;
    logic [5:0]  pkt_dt;
    logic [15:0] pkt_wc;
    logic        hdr_valid, frame_valid, line_valid;
    logic        ecc_err, skew_err, trunc_err;

    always #5 clk = ~clk;

    csi2_packet_ctrl #(.SKEW_MAX(7)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .l0_hs_mode   (l0_hs_mode),
        .l1_hs_mode   (l1_hs_mode),
        .l0_found_sot (l0_found_sot),
        .l1_found_sot (l1_found_sot),
        .l0_byte_gate (l0_byte_gate),
        .l1_byte_gate (l1_byte_gate),
        .l0_byte      (l0_byte),
        .l1_byte      (l1_byte),
        .pix_data     (pix_data),
        .pix_be       (pix_be),
        .pix_valid    (pix_valid),
        .pkt_vc       (pkt_vc),
        .pkt_dt       (pkt_dt),
        .pkt_wc       (pkt_wc),
        .hdr_valid    (hdr_valid),
        .frame_valid  (frame_valid),
        .line_valid   (line_valid),
        .ecc_err      (ecc_err),
        .skew_err     (skew_err),
        .trunc_err    (trunc_err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_hdr   = 0;
    int n_ecc   = 0;
    int n_skew  = 0;
    int n_trunc = 0;
    logic [17:0] pix_q [$];

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (pix_valid) pix_q.push_back({pix_be, pix_data});
        if (hdr_valid) n_hdr = n_hdr + 1;
        if (ecc_err)   n_ecc = n_ecc + 1;
        if (skew_err)  n_skew = n_skew + 1;
        if (trunc_err) n_trunc = n_trunc + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    function automatic logic [31:0] pix_at(input int i);
        if (i < pix_q.size()) return 32'(pix_q[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_pkt();
        l0_hs_mode = 1'b1; l1_hs_mode = 1'b1;
        l0_found_sot = 1'b1; l1_found_sot = 1'b1;
        tick();
    endtask

    task automatic end_pkt();
        tick(3);
        l0_hs_mode = 1'b0; l1_hs_mode = 1'b0;
        l0_found_sot = 1'b0; l1_found_sot = 1'b0;
        tick(2);
    endtask

    // One beat: lane 1 strobes 'lag' cycles after lane 0.
    task automatic beat(input logic [7:0] b0, input logic [7:0] b1, input int lag = 0);
        if (lag == 0) begin
            l0_byte = b0; l1_byte = b1;
            l0_byte_gate = 1'b1; l1_byte_gate = 1'b1;
            tick();
            l0_byte_gate = 1'b0; l1_byte_gate = 1'b0;
        end else begin
            l0_byte = b0; l0_byte_gate = 1'b1;
            tick();
            l0_byte_gate = 1'b0;
            if (lag > 1) tick(lag - 1);
            l1_byte = b1; l1_byte_gate = 1'b1;
            tick();
            l1_byte_gate = 1'b0;
        end
    endtask

    task automatic send_hdr(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc);
        beat(di, wc[7:0]);
        beat(wc[15:8], ecc);
    endtask

    initial begin
        int h0, e0, s0, t0;
        rstn = 1'b0;
        l0_hs_mode = 0; l1_hs_mode = 0; l0_found_sot = 0; l1_found_sot = 0;
        l0_byte_gate = 0; l1_byte_gate = 0; l0_byte = 0; l1_byte = 0;
        tick(3);
        check_val("rst_pix", {13'd0, pix_valid, pix_be, pix_data}, 32'd0);
        check_val("rst_pkt", {6'd0, pkt_vc, pkt_dt, pkt_wc}, 32'd0);
        check_val("rst_flags", {26'd0, hdr_valid, frame_valid, line_valid, ecc_err, skew_err, trunc_err}, 32'd0);
        rstn = 1'b1;
        tick(2);

        // Frame start, ECC 0x00
        h0 = n_hdr;
        start_pkt(); send_hdr(8'h00, 16'h0000, 8'h00); end_pkt();
        check_val("fs_hdr_pulse", n_hdr - h0, 1);
        check_val("fs_dt", pkt_dt, 6'h00);
        check_val("fs_frame", frame_valid, 1'b1);

        // Second frame start while frame already open
        h0 = n_hdr;
        start_pkt(); send_hdr(8'h00, 16'h0000, 8'h00); end_pkt();
        check_val("fs2_hdr_pulse", n_hdr - h0, 1);
        check_val("fs2_frame", frame_valid, 1'b1);

        // Line start, ECC 0x0B
        start_pkt(); send_hdr(8'h02, 16'h0000, 8'h0B); end_pkt();
        check_val("ls_line", line_valid, 1'b1);

        // Long packet DT 0x2A, WC 5, ECC 0x29; extra beat after CRC must be ignored
        pix_q.delete(); h0 = n_hdr;
        start_pkt(); send_hdr(8'h2A, 16'd5, 8'h29);
        beat(8'h11, 8'h22); beat(8'h33, 8'h44); beat(8'h55, 8'hC0); beat(8'hC1, 8'h00);
        beat(8'h77, 8'h88);
        end_pkt();
        check_val("long_hdr_pulse", n_hdr - h0, 1);
        check_val("long_dt", pkt_dt, 6'h2A);
        check_val("long_wc", pkt_wc, 16'd5);
        check_val("long_beats", pix_q.size(), 3);
        check_val("long_beat0", pix_at(0), 32'h3_2211);
        check_val("long_beat1", pix_at(1), 32'h3_4433);
        check_val("long_beat2", pix_at(2), 32'h1_C055);

        // Lane skew of 7 cycles: still a normal beat (WC 2, ECC 0x0C)
        pix_q.delete(); s0 = n_skew;
        start_pkt(); send_hdr(8'h2A, 16'd2, 8'h0C);
        beat(8'hAA, 8'hBB, 7); beat(8'hCC, 8'hDD);
        end_pkt();
        check_val("skew7_err", n_skew - s0, 0);
        check_val("skew7_beats", pix_q.size(), 1);
        check_val("skew7_beat0", pix_at(0), 32'h3_BBAA);

        // Lane skew of 8 cycles: skew error, no payload
        pix_q.delete(); s0 = n_skew; t0 = n_trunc;
        start_pkt(); send_hdr(8'h2A, 16'd2, 8'h0C);
        beat(8'hAA, 8'hBB, 8);
        end_pkt();
        check_val("skew8_err", n_skew - s0, 1);
        check_val("skew8_beats", pix_q.size(), 0);
        check_val("skew8_trunc", n_trunc - t0, 0);

        // Truncation after 2 of 10 payload bytes
        pix_q.delete(); t0 = n_trunc;
        start_pkt(); send_hdr(8'h2A, 16'd10, 8'h29);
        beat(8'h01, 8'h02);
        tick(2);
        l0_hs_mode = 1'b0;
        tick(3);
        check_val("trunc_err", n_trunc - t0, 1);
        check_val("trunc_beats", pix_q.size(), 1);
        check_val("trunc_frame", frame_valid, 1'b1);
        check_val("trunc_line", line_valid, 1'b1);
        l1_hs_mode = 1'b0; l0_found_sot = 1'b0; l1_found_sot = 1'b0;
        tick(2);

        // Following packet: frame end, ECC 0x07
        h0 = n_hdr;
        start_pkt(); send_hdr(8'h01, 16'h0000, 8'h07); end_pkt();
        check_val("fe_hdr_pulse", n_hdr - h0, 1);
        check_val("fe_dt", pkt_dt, 6'h01);
        check_val("fe_frame_line", {frame_valid, line_valid}, 2'b00);

        // Frame start with ECC bit 0 flipped
        h0 = n_hdr; e0 = n_ecc;
        start_pkt(); send_hdr(8'h00, 16'h0000, 8'h01); end_pkt();
        check_val("eccflip_hdr_pulse", n_hdr - h0, 1);
`ifdef CSI2_ECC_CHECK_EN
        check_val("eccflip_err", n_ecc - e0, 1);
        check_val("eccflip_dt", pkt_dt, 6'h01);
        check_val("eccflip_frame", frame_valid, 1'b0);
`else
        check_val("eccflip_err", n_ecc - e0, 0);
        check_val("eccflip_dt", pkt_dt, 6'h00);
        check_val("eccflip_frame", frame_valid, 1'b1);
`endif

        // Reset in the middle of a payload
        pix_q.delete(); e0 = n_ecc; s0 = n_skew; t0 = n_trunc;
        start_pkt(); send_hdr(8'h2A, 16'd10, 8'h29);
        beat(8'h01, 8'h02); beat(8'h03, 8'h04);
        tick(2);
        check_val("mid_beats", pix_q.size(), 2);
        check_val("mid_wc", pkt_wc, 16'd10);
        rstn = 1'b0;
        #2;
        check_val("mid_rst_pix", {13'd0, pix_valid, pix_be, pix_data}, 32'd0);
        check_val("mid_rst_pkt", {6'd0, pkt_vc, pkt_dt, pkt_wc}, 32'd0);
        check_val("mid_rst_flags", {26'd0, hdr_valid, frame_valid, line_valid, ecc_err, skew_err, trunc_err}, 32'd0);
        l0_hs_mode = 0; l1_hs_mode = 0; l0_found_sot = 0; l1_found_sot = 0;
        tick(2);
        rstn = 1'b1;
        tick(3);
        check_val("mid_rst_no_err", (n_ecc - e0) + (n_skew - s0) + (n_trunc - t0), 0);
        check_val("mid_rst_no_pix", pix_q.size(), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
